// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: turns memory, jump, load-use and
// fetch hazards into per-stage stall/bubble/flush controls and keeps stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int FLUSH_HOLD = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             if_busy,
   input  logic             mem_busy,
   input  logic             ex_jump,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   output logic             if_stall,
   output logic             if_id_stall,
   output logic             id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             mem_wb_bubble,
   output logic             jump_or_not,
   output logic             if_discard,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);

   state_t           state_reg, state_next;
   logic [2:0]       hold_reg, hold_next;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
   logic             load_use;
   logic             fetch_wait;
   logic             jump_accept;
   logic             any_stall;

   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // Fetch stalls are meaningless while the squashed path is being discarded.
   assign fetch_wait = if_busy && (state_reg == RUN);

   always_comb begin
      if_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_stall      = 1'b0;
      id_ex_stall   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      jump_or_not   = 1'b0;
      jump_accept   = 1'b0;
      state_next    = state_reg;
      hold_next     = hold_reg;

      if (rst || !rdy) begin
         if_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
      end else begin
         if (mem_busy) begin
            if_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
         end else if (ex_jump) begin
            jump_or_not = 1'b1;
            jump_accept = 1'b1;
         end else if (load_use) begin
            if_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_stall    = 1'b1;
         end else if (fetch_wait) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
         end

         if (jump_accept) begin
            state_next = FLUSH;
            hold_next  = HOLD_INIT;
         end else if (state_reg == FLUSH) begin
            hold_next = hold_reg - 3'd1;
            if (hold_reg == 3'd1)
               state_next = RUN;
         end
      end
   end

   assign any_stall  = if_stall | if_id_stall | id_ex_stall | ex_mem_stall;
   assign if_discard = (state_reg == FLUSH) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= RUN;
         hold_reg      <= 3'd0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else if (rdy) begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         // Counters saturate so long runs never wrap to misleading small values.
         if (any_stall && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (jump_accept && !(&flush_cnt_reg))
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

endmodule
